// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/response handshake bundle for the sequential ALU
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       ALUControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic [3:0]       ALUFlags;
  logic             div_by_zero;

  modport master (
    output in_valid, a, b, ALUControl, out_ready,
    input  in_ready, out_valid, Result, ALUFlags, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, ALUControl, out_ready,
    output in_ready, out_valid, Result, ALUFlags, div_by_zero
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with iterative shift-subtract divider
// Define ALU_SEQ_REMAINDER_EN to add signed (010) / unsigned (011) remainder.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_SDIV = 3'b101;
  localparam logic [2:0] OP_UDIV = 3'b111;
`ifdef ALU_SEQ_REMAINDER_EN
  localparam logic [2:0] OP_SREM = 3'b010;
  localparam logic [2:0] OP_UREM = 3'b011;
`endif

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;
  state_t state, state_nx;

  logic [2:0]       op;
  logic [WIDTH-1:0] a, b;
  assign op = bus.ALUControl;
  assign a  = bus.a;
  assign b  = bus.b;

  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             dbz_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quo_q;
  logic             ovf_q;
`ifdef ALU_SEQ_REMAINDER_EN
  logic             neg_rem_q;
  logic             rem_sel_q;
`endif

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.Result      = result_q;
  assign bus.ALUFlags    = flags_q;
  assign bus.div_by_zero = dbz_q;

  // Operation decode
  logic is_div, is_signed, b_zero;
`ifdef ALU_SEQ_REMAINDER_EN
  logic is_rem;
`endif
  always_comb begin
    is_div    = 1'b0;
    is_signed = 1'b0;
`ifdef ALU_SEQ_REMAINDER_EN
    is_rem    = 1'b0;
`endif
    case (op)
      OP_SDIV: begin is_div = 1'b1; is_signed = 1'b1; end
      OP_UDIV: is_div = 1'b1;
`ifdef ALU_SEQ_REMAINDER_EN
      OP_SREM: begin is_div = 1'b1; is_signed = 1'b1; is_rem = 1'b1; end
      OP_UREM: begin is_div = 1'b1; is_rem = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign b_zero = (b == '0);

  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Single-cycle datapath; also supplies the zero-divisor result
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v;
  assign b_op = op[0] ? ~b : b;
  assign sum  = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, op[0]};

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ op[0]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
      end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
`ifdef ALU_SEQ_REMAINDER_EN
      OP_SREM, OP_UREM: sc_res = a;
`endif
      default: sc_res = '0;
    endcase
  end

  // One restoring-division step: remainder is widened by one bit for the trial subtract
  logic [WIDTH:0] rem_sh, diff;
  logic           fits;
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign fits   = ~diff[WIDTH];

  logic [WIDTH-1:0] quo_fix, fix_res;
  assign quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
`ifdef ALU_SEQ_REMAINDER_EN
  logic [WIDTH-1:0] rem_fix;
  assign rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
  assign fix_res = rem_sel_q ? rem_fix : quo_fix;
`else
  assign fix_res = quo_fix;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.in_valid) state_nx = (is_div && !b_zero) ? DIV : DONE;
      DIV:  if (cnt_q == CNT_W'(1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q  <= '0;
      flags_q   <= '0;
      dbz_q     <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef ALU_SEQ_REMAINDER_EN
      neg_rem_q <= 1'b0;
      rem_sel_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          neg_quo_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          ovf_q     <= (op == OP_SDIV) && (a == MIN_VAL) && (b == '1);
`ifdef ALU_SEQ_REMAINDER_EN
          neg_rem_q <= is_signed & a[WIDTH-1];
          rem_sel_q <= is_rem;
`endif
          rem_q <= '0;
          quo_q <= a_mag;
          dvs_q <= b_mag;
          cnt_q <= CNT_W'(WIDTH);
          if (is_div && !b_zero) begin
            dbz_q <= 1'b0;
          end else begin
            result_q <= sc_res;
            flags_q  <= {sc_res[WIDTH-1], sc_res == '0, sc_c, sc_v};
            dbz_q    <= is_div;
          end
        end
        DIV: begin
          rem_q <= fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], fits};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        FIX: begin
          // MIN / -1 wraps to MIN naturally; only the overflow flag needs help
          result_q <= fix_res;
          flags_q  <= {fix_res[WIDTH-1], fix_res == '0, 1'b0, ovf_q};
        end
        default: ;
      endcase
    end
  end
endmodule
